// File: rtl/vga_scanout.sv
// Raster timing generator for the VGA display path: pixel prescaler, h/v counters,
// and a one-pixel-period registered RGB/sync output stage with a frame tick.
module vga_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIX_DIV  = 1
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] colPos,
    output logic [9:0] rowPos,
    output logic       on,
    input  logic [5:0] color,
    output logic [1:0] vga_r,
    output logic [1:0] vga_g,
    output logic [1:0] vga_b,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int PDW     = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [PDW-1:0] PDIV_LAST = PDW'(PIX_DIV - 1);
    localparam logic [PDW-1:0] PDIV_ONE  = PDW'(1);
    localparam logic [9:0]     H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]     V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]     H_ACT     = 10'(H_ACTIVE);
    localparam logic [9:0]     V_ACT     = 10'(V_ACTIVE);
    // Sync windows compared at 11 bits so an end bound of 1024 cannot alias to 0.
    localparam logic [10:0]    HS_BEG    = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0]    HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0]    VS_BEG    = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0]    VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [PDW-1:0] pdiv_q, pdiv_d;
    logic [9:0]     hcnt_q, hcnt_d;
    logic [9:0]     vcnt_q, vcnt_d;
    logic [5:0]     rgb_q, rgb_d;
    logic           hs_q, hs_d;
    logic           vs_q, vs_d;

    logic           pix_en_s;
    logic           on_s;
    logic           line_end_s;
    logic           hs_act_s;
    logic           vs_act_s;

    // Decode enables and windows from the current counter registers.
    always_comb begin
        pix_en_s   = (pdiv_q == PDIV_LAST);
        on_s       = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        line_end_s = (hcnt_q == H_LAST);
        hs_act_s   = ({1'b0, hcnt_q} >= HS_BEG) && ({1'b0, hcnt_q} < HS_END);
        vs_act_s   = ({1'b0, vcnt_q} >= VS_BEG) && ({1'b0, vcnt_q} < VS_END);
    end

    // Next state: everything except the prescaler advances only on a pixel enable.
    always_comb begin
        pdiv_d = pdiv_q;
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        rgb_d  = rgb_q;
        hs_d   = hs_q;
        vs_d   = vs_q;
        if (pix_en_s) begin
            pdiv_d = '0;
            if (line_end_s) begin
                hcnt_d = 10'd0;
                if (vcnt_q == V_LAST) begin
                    vcnt_d = 10'd0;
                end else begin
                    vcnt_d = vcnt_q + 10'd1;
                end
            end else begin
                hcnt_d = hcnt_q + 10'd1;
                vcnt_d = vcnt_q;
            end
            rgb_d = on_s ? color : 6'd0;
            hs_d  = ~hs_act_s;
            vs_d  = ~vs_act_s;
        end else begin
            pdiv_d = pdiv_q + PDIV_ONE;
        end
    end

    // State and output-stage registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pdiv_q <= '0;
            hcnt_q <= 10'd0;
            vcnt_q <= 10'd0;
            rgb_q  <= 6'd0;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
        end else begin
            pdiv_q <= pdiv_d;
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            rgb_q  <= rgb_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
        end
    end

    assign colPos     = hcnt_q;
    assign rowPos     = vcnt_q;
    assign on         = on_s;
    assign vga_r      = rgb_q[5:4];
    assign vga_g      = rgb_q[3:2];
    assign vga_b      = rgb_q[1:0];
    assign hsync_n    = hs_q;
    assign vsync_n    = vs_q;
    assign frame_tick = (hcnt_q == 10'd0) && (vcnt_q == V_ACT) && pix_en_s;

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Raster timing generator and pixel output stage for the 640x480@60 Hz display path. It drives `colPos`, `rowPos` and `on` into the combinational pixel generators (background, sprites, priority mux). It samples the 6-bit `color` they return, blanks it, and registers it onto the VGA RGB pins. Sync pulses are delayed by the same amount so that they stay aligned with the pixels. It also emits a once-per-frame tick that game logic uses to update state during vertical blanking.

## Interface
Parameters:
- `H_ACTIVE` 640: visible columns
- `H_FP` 16: horizontal front porch, in pixels
- `H_SYNC` 96: hsync width, in pixels
- `H_BP` 48: horizontal back porch (H_TOTAL = 800)
- `V_ACTIVE` 480: visible lines
- `V_FP` 10: vertical front porch, in lines
- `V_SYNC` 2: vsync width, in lines
- `V_BP` 33: vertical back porch (V_TOTAL = 525)
- `PIX_DIV` 1: clock cycles per pixel (1 = 25 MHz clk, 2 = 50 MHz clk)

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `colPos` out 10: current horizontal count, 0..H_TOTAL-1.
- `rowPos` out 10: current vertical count, 0..V_TOTAL-1.
- `on` out 1: high when colPos < H_ACTIVE and rowPos < V_ACTIVE.
- `color` in 6: pixel colour for the current (colPos, rowPos), packed {R[1:0], G[1:0], B[1:0]}; returned combinationally in the same cycle.
- `vga_r`, `vga_g`, `vga_b` out 2 each: registered pixel output.
- `hsync_n`, `vsync_n` out 1: registered syncs, active low.
- `frame_tick` out 1: one pixel period wide, at the start of vertical blank.

## Operation
- **Prescaler.** `pdiv` counts 0..PIX_DIV-1 and wraps. `pix_en` = (pdiv == PIX_DIV-1). With PIX_DIV = 1, `pix_en` is constantly 1.
- **Horizontal counter.** `hcnt` increments on `pix_en` and wraps from H_TOTAL-1 to 0.
- **Vertical counter.** `vcnt` increments on `pix_en` only when `hcnt` == H_TOTAL-1, and wraps from V_TOTAL-1 to 0.
- **Position outputs.** `colPos` = `hcnt` and `rowPos` = `vcnt`, both taken directly from the registers (no combinational path). Both run through the blanking ranges; they are not clamped.
- **Stage 1 registers** (update on `pix_en` only):
  - `vga_r`/`vga_g`/`vga_b` ← `on` ? `color` fields : 0
  - `hsync_n` ← !(H_ACTIVE+H_FP ≤ `hcnt` < H_ACTIVE+H_FP+H_SYNC), i.e. low for hcnt 656..751
  - `vsync_n` ← !(V_ACTIVE+V_FP ≤ `vcnt` < V_ACTIVE+V_FP+V_SYNC), i.e. low for vcnt 490..491
- **Frame tick.** `frame_tick` = (`hcnt` == 0) && (`vcnt` == V_ACTIVE) && `pix_en`. It is decoded from the registers and is high for exactly one clk cycle per frame.
- **Colour bits.** `color` is never altered except by blanking. Bits [5:4] go to R, [3:2] to G, [1:0] to B.
- **Counter widths.** The counters are 10 bits, so every parameter total must be ≤ 1024; this is not checked in hardware. Wrap comparisons use equality to TOTAL-1, never overflow.

## Timing
- **Reset values.** On `reset` assertion, immediately (asynchronously):
  - `pdiv`, `hcnt`, `vcnt` = 0
  - `vga_r`/`vga_g`/`vga_b` = 0
  - `hsync_n` = `vsync_n` = 1
  - `frame_tick` = 0
  - hence `colPos` = `rowPos` = 0 and `on` = 1
- **After reset release.**
  - The first rising edge with `pix_en` advances the counters to (1,0).
  - That same edge registers the pixel for (0,0) into RGB.
- **Pipeline latency.** The pixel at (x,y) appears on `vga_*` exactly one pixel period (PIX_DIV clks) after `colPos`/`rowPos` present (x,y). The syncs carry the same delay, so RGB/sync alignment is exact.
- **Frame period.** The frame is 800 × 525 = 420000 pixel periods. `frame_tick` rises 420000 × PIX_DIV clks apart.
- **End-of-frame wrap.** At (799,524) the next `pix_en` edge wraps both counters to (0,0) in the same cycle.
- **Reset mid-line.** Outputs return to their reset values within the same cycle. No partial sync pulse is held low.
- **Between enables.** When PIX_DIV > 1, all outputs hold between `pix_en` cycles.

## Test plan
- **Reset.** Assert `reset` at an arbitrary point while `hsync_n` is low. Required: `hsync_n` = 1, RGB = 0, `colPos` = 0, `rowPos` = 0 without waiting for a clock edge. Release: `colPos` reads 1 one clk later (PIX_DIV = 1).
- **Line timing.** PIX_DIV = 1; measure `hsync_n`. Required:
  - low for exactly 96 clks
  - falling edge 657 clks after `colPos` = 0, measured at the output
  - period 800 clks
  - `on` low for colPos 640..799
- **Frame timing.**
  - `vsync_n` is low for exactly 2 lines (1600 clks).
  - `rowPos` wraps from 524 to 0 at the same time as `colPos` wraps from 799 to 0.
  - `frame_tick` pulses exactly once, at `colPos` = 0 and `rowPos` = 480, and again 420000 clks later.
- **Pixel path.** Drive `color` = 6'b010011 when colPos = 5, else 0. Required:
  - `vga_r` = 01, `vga_g` = 00, `vga_b` = 11 for exactly one pixel, one pixel period later.
  - Driving `color` = 6'b111111 during colPos 640..799 or rowPos ≥ 480 yields RGB = 0.
- **Divider.** PIX_DIV = 2. Required:
  - `colPos` holds each value for 2 clks.
  - `hsync_n` is low for 192 clks.
  - the line is 1600 clks.
  - `frame_tick` is high for 1 clk per 840000 clks.
- **Bench cross-check.** Connect the background generator to `color`. Required: RGB matches the generator's reference model at every active pixel of one full frame, using the one-pixel pipeline offset.
